pipeline_hazard_controller: RTL and testbench

- Sequences the 5-stage MIPS pipeline around hazards the forwarding unit cannot resolve: load-use, taken-branch flush, multi-cycle data-memory access and the iterative mul/div unit.
- Drives PC and pipeline-register write enables, flushes and bubbles.
- Keeps a saturating stall counter and a sticky memory-timeout flag.

---
 rtl/hazard_pkg.sv | 19 +
 rtl/load_use_detect.sv | 25 ++
 rtl/pipeline_hazard_controller.sv | 131 +++++++++++++
 tb/tb_pipeline_hazard_controller.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hazard_pkg
// Description : Shared state encoding and register constants for the
//               pipeline hazard controller and its decode-stage helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package hazard_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    MD_WAIT  = 2'd2
  } state_t;

  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage
`default_nettype wire

// File: rtl/load_use_detect.sv
`default_nettype none
// ============================================================================
// Module      : load_use_detect
// Description : Combinational load-use comparator between the load in EX and
//               the instruction in ID.
// Revision    : 1.0 - initial release
// ============================================================================
module load_use_detect
  import hazard_pkg::*;
(
  input  logic       idEx_MemRead,
  input  logic [4:0] idEx_RegRt,
  input  logic [4:0] ifId_RegRs,
  input  logic [4:0] ifId_RegRt,
  input  logic       ifId_UsesRt,
  output logic       hazard
);

  // $zero is never a real dependency, so a load targeting it cannot stall.
  assign hazard = idEx_MemRead && (idEx_RegRt != REG_ZERO) &&
                  ((idEx_RegRt == ifId_RegRs) ||
                   (ifId_UsesRt && (idEx_RegRt == ifId_RegRt)));

endmodule
`default_nettype wire

// File: rtl/pipeline_hazard_controller.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_hazard_controller
// Description : Stall/flush sequencer for the 5-stage MIPS pipeline covering
//               load-use, taken branch, multi-cycle memory and mul/div.
// Revision    : 1.0 - initial release
// ============================================================================
module pipeline_hazard_controller
  import hazard_pkg::*;
#(
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       ifId_RegRs,
  input  logic [4:0]       ifId_RegRt,
  input  logic             ifId_UsesRt,
  input  logic             idEx_MemRead,
  input  logic [4:0]       idEx_RegRt,
  input  logic             idEx_MulDiv,
  input  logic             branch_taken,
  input  logic             exMem_MemAccess,
  input  logic             mem_ready,
  input  logic             muldiv_done,
  output logic             pcWrite,
  output logic             ifIdWrite,
  output logic             ifIdFlush,
  output logic             idExWrite,
  output logic             idExFlush,
  output logic             exMemWrite,
  output logic             exMemBubble,
  output logic             memWbBubble,
  output logic             muldiv_start,
  output logic [CNT_W-1:0] stall_cycles,
  output logic             mem_timeout
);

  localparam int                WAIT_W     = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] c_waitMax  = WAIT_W'(MEM_TIMEOUT);
  localparam logic [WAIT_W-1:0] c_waitLast = WAIT_W'(MEM_TIMEOUT - 1);

  state_t            r_state;
  state_t            w_nextState;
  logic [WAIT_W-1:0] r_waitCnt;
  logic [CNT_W-1:0]  r_stallCnt;
  logic              r_memTimeout;
  logic              w_loadUse;

  load_use_detect u_loadUse (
    .idEx_MemRead (idEx_MemRead),
    .idEx_RegRt   (idEx_RegRt),
    .ifId_RegRs   (ifId_RegRs),
    .ifId_RegRt   (ifId_RegRt),
    .ifId_UsesRt  (ifId_UsesRt),
    .hazard       (w_loadUse)
  );

  // On a mem_ready or muldiv_done cycle the corresponding stall term is
  // already false, so the plain RUN priority chain gives the right result.
  always_comb begin
    pcWrite      = 1'b1;
    ifIdWrite    = 1'b1;
    ifIdFlush    = 1'b0;
    idExWrite    = 1'b1;
    idExFlush    = 1'b0;
    exMemWrite   = 1'b1;
    exMemBubble  = 1'b0;
    memWbBubble  = 1'b0;
    muldiv_start = 1'b0;
    w_nextState  = RUN;
    if (reset) begin
      w_nextState = RUN;
    end else if (((r_state == MEM_WAIT) && !mem_ready) ||
                 ((r_state != MEM_WAIT) && exMem_MemAccess && !mem_ready)) begin
      pcWrite     = 1'b0;
      ifIdWrite   = 1'b0;
      idExWrite   = 1'b0;
      exMemWrite  = 1'b0;
      memWbBubble = 1'b1;
      w_nextState = MEM_WAIT;
    end else if (((r_state == MD_WAIT) && !muldiv_done) ||
                 ((r_state != MD_WAIT) && idEx_MulDiv && !muldiv_done)) begin
      pcWrite      = 1'b0;
      ifIdWrite    = 1'b0;
      idExWrite    = 1'b0;
      exMemBubble  = 1'b1;
      muldiv_start = (r_state != MD_WAIT);
      w_nextState  = MD_WAIT;
    end else if (branch_taken) begin
      ifIdFlush = 1'b1;
      idExFlush = 1'b1;
    end else if (w_loadUse) begin
      pcWrite   = 1'b0;
      ifIdWrite = 1'b0;
      idExFlush = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= RUN;
      r_waitCnt    <= '0;
      r_stallCnt   <= '0;
      r_memTimeout <= 1'b0;
    end else begin
      r_state <= w_nextState;
      if (!pcWrite && (r_stallCnt != {CNT_W{1'b1}})) begin
        r_stallCnt <= r_stallCnt + 1'b1;
      end
      // The timeout only flags the condition; the stall itself continues.
      if (r_state == MEM_WAIT) begin
        if (r_waitCnt >= c_waitLast) begin
          r_memTimeout <= 1'b1;
        end
        if (mem_ready) begin
          r_waitCnt <= '0;
        end else if (r_waitCnt != c_waitMax) begin
          r_waitCnt <= r_waitCnt + 1'b1;
        end
      end else begin
        r_waitCnt <= '0;
      end
    end
  end

  assign stall_cycles = r_stallCnt;
  assign mem_timeout  = r_memTimeout;

endmodule
`default_nettype wire

// File: tb/tb_pipeline_hazard_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipeline_hazard_controller
// Description : Scoreboard bench for the pipeline hazard controller.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipeline_hazard_controller;

  // Control vector order: pcWrite ifIdWrite ifIdFlush idExWrite idExFlush
  //                       exMemWrite exMemBubble memWbBubble muldiv_start
  localparam logic [8:0] NORM    = 9'b110101000;
  localparam logic [8:0] MEMF    = 9'b000000010;
  localparam logic [8:0] MDSTART = 9'b000001101;
  localparam logic [8:0] MDWAIT  = 9'b000001100;
  localparam logic [8:0] BR      = 9'b111111000;
  localparam logic [8:0] LU      = 9'b000111000;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  ifId_RegRs, ifId_RegRt, idEx_RegRt;
  logic        ifId_UsesRt, idEx_MemRead, idEx_MulDiv, branch_taken;
  logic        exMem_MemAccess, mem_ready, muldiv_done;
  logic        pcWrite, ifIdWrite, ifIdFlush, idExWrite, idExFlush;
  logic        exMemWrite, exMemBubble, memWbBubble, muldiv_start;
  logic [15:0] stall_cycles;
  logic        mem_timeout;

  logic [25:0] expQ[$];
  logic [25:0] obsQ[$];
  logic [25:0] e, o;
  logic [15:0] expCnt;
  logic        expTo;
  int          tests = 0;
  int          failed = 0;

  always #5 clk = ~clk;

  pipeline_hazard_controller #(.MEM_TIMEOUT(2), .CNT_W(16)) dut (
    .clk(clk), .reset(reset),
    .ifId_RegRs(ifId_RegRs), .ifId_RegRt(ifId_RegRt), .ifId_UsesRt(ifId_UsesRt),
    .idEx_MemRead(idEx_MemRead), .idEx_RegRt(idEx_RegRt), .idEx_MulDiv(idEx_MulDiv),
    .branch_taken(branch_taken), .exMem_MemAccess(exMem_MemAccess),
    .mem_ready(mem_ready), .muldiv_done(muldiv_done),
    .pcWrite(pcWrite), .ifIdWrite(ifIdWrite), .ifIdFlush(ifIdFlush),
    .idExWrite(idExWrite), .idExFlush(idExFlush), .exMemWrite(exMemWrite),
    .exMemBubble(exMemBubble), .memWbBubble(memWbBubble),
    .muldiv_start(muldiv_start), .stall_cycles(stall_cycles),
    .mem_timeout(mem_timeout)
  );

  task automatic idle();
    ifId_RegRs = 5'd0; ifId_RegRt = 5'd0; ifId_UsesRt = 1'b0;
    idEx_MemRead = 1'b0; idEx_RegRt = 5'd0; idEx_MulDiv = 1'b0;
    branch_taken = 1'b0; exMem_MemAccess = 1'b0; mem_ready = 1'b1;
    muldiv_done = 1'b0;
  endtask

  // Inputs are set on the falling edge; outputs are sampled shortly before
  // the rising edge, and the bench's own counter model advances afterwards.
  task automatic step(input logic [8:0] ctl);
    #3;
    expQ.push_back({ctl, expTo, expCnt});
    obsQ.push_back({pcWrite, ifIdWrite, ifIdFlush, idExWrite, idExFlush,
                    exMemWrite, exMemBubble, memWbBubble, muldiv_start,
                    mem_timeout, stall_cycles});
    @(posedge clk);
    if (reset) begin
      expCnt = 16'd0;
      expTo  = 1'b0;
    end else if (!ctl[8] && expCnt != 16'hFFFF) begin
      expCnt = expCnt + 16'd1;
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1; idle();
    @(posedge clk); @(negedge clk);
    expCnt = 16'd0; expTo = 1'b0;
    step(NORM);
    reset = 1'b0;
    step(NORM);
    while (expQ.size() > 0) begin
      e = expQ.pop_front(); o = obsQ.pop_front(); tests++;
      if (o !== e) begin failed++; $display("FAIL reset: got %b want %b", o, e); end
    end
  endtask

  task automatic test_load_use();
    idEx_MemRead = 1'b1; idEx_RegRt = 5'd2; ifId_RegRs = 5'd2; ifId_RegRt = 5'd7;
    step(LU);
    idEx_MemRead = 1'b0;
    step(NORM);
    ifId_UsesRt = 1'b1; ifId_RegRs = 5'd9; ifId_RegRt = 5'd4;
    idEx_MemRead = 1'b1; idEx_RegRt = 5'd4;
    step(LU);
    idle();
    step(NORM);
    while (expQ.size() > 0) begin
      e = expQ.pop_front(); o = obsQ.pop_front(); tests++;
      if (o !== e) begin failed++; $display("FAIL load_use: got %b want %b", o, e); end
    end
  endtask

  task automatic test_no_stall();
    idEx_MemRead = 1'b1; idEx_RegRt = 5'd0; ifId_RegRs = 5'd0;
    step(NORM);
    idEx_RegRt = 5'd5; ifId_RegRs = 5'd3; ifId_RegRt = 5'd5; ifId_UsesRt = 1'b0;
    step(NORM);
    idle();
    while (expQ.size() > 0) begin
      e = expQ.pop_front(); o = obsQ.pop_front(); tests++;
      if (o !== e) begin failed++; $display("FAIL no_stall: got %b want %b", o, e); end
    end
  endtask

  task automatic test_branch();
    idEx_MemRead = 1'b1; idEx_RegRt = 5'd6; ifId_RegRs = 5'd6; branch_taken = 1'b1;
    step(BR);
    idle();
    step(NORM);
    while (expQ.size() > 0) begin
      e = expQ.pop_front(); o = obsQ.pop_front(); tests++;
      if (o !== e) begin failed++; $display("FAIL branch: got %b want %b", o, e); end
    end
  endtask

  task automatic test_muldiv();
    idEx_MulDiv = 1'b1;
    step(MDSTART);
    for (int i = 0; i < 4; i++) step(MDWAIT);
    muldiv_done = 1'b1;
    step(NORM);
    idle();
    step(NORM);
    while (expQ.size() > 0) begin
      e = expQ.pop_front(); o = obsQ.pop_front(); tests++;
      if (o !== e) begin failed++; $display("FAIL muldiv: got %b want %b", o, e); end
    end
  endtask

  task automatic test_mem_wait();
    exMem_MemAccess = 1'b1; mem_ready = 1'b0;
    step(MEMF);
    step(MEMF);
    step(MEMF);
    expTo = 1'b1;
    mem_ready = 1'b1;
    step(NORM);
    idle();
    step(NORM);
    while (expQ.size() > 0) begin
      e = expQ.pop_front(); o = obsQ.pop_front(); tests++;
      if (o !== e) begin failed++; $display("FAIL mem_wait: got %b want %b", o, e); end
    end
  endtask

  task automatic test_branch_in_mem_wait();
    exMem_MemAccess = 1'b1; mem_ready = 1'b0; branch_taken = 1'b1;
    step(MEMF);
    step(MEMF);
    mem_ready = 1'b1;
    step(BR);
    idle();
    step(NORM);
    while (expQ.size() > 0) begin
      e = expQ.pop_front(); o = obsQ.pop_front(); tests++;
      if (o !== e) begin failed++; $display("FAIL branch_mem_wait: got %b want %b", o, e); end
    end
  endtask

  task automatic test_reset_mid_md();
    idEx_MulDiv = 1'b1;
    step(MDSTART);
    step(MDWAIT);
    reset = 1'b1;
    step(NORM);
    reset = 1'b0; idle();
    step(NORM);
    step(NORM);
    while (expQ.size() > 0) begin
      e = expQ.pop_front(); o = obsQ.pop_front(); tests++;
      if (o !== e) begin failed++; $display("FAIL reset_mid_md: got %b want %b", o, e); end
    end
  endtask

  task automatic test_saturate();
    exMem_MemAccess = 1'b1; mem_ready = 1'b0;
    repeat (65540) @(posedge clk);
    @(negedge clk);
    expCnt = 16'hFFFF; expTo = 1'b1;
    step(MEMF);
    step(MEMF);
    mem_ready = 1'b1;
    step(NORM);
    idle();
    while (expQ.size() > 0) begin
      e = expQ.pop_front(); o = obsQ.pop_front(); tests++;
      if (o !== e) begin failed++; $display("FAIL saturate: got %b want %b", o, e); end
    end
  endtask

  initial begin
    reset = 1'b1;
    idle();
    @(negedge clk);
    test_reset();
    test_load_use();
    test_no_stall();
    test_branch();
    test_muldiv();
    test_mem_wait();
    test_branch_in_mem_wait();
    test_reset_mid_md();
    test_saturate();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
`default_nettype wire
